// File: rtl/csr_regfile_if.sv
// Pipeline-side CSR bus: combinational read port, CSR write port and the
// writeback-stage exception/ertn commit signals.
interface csr_regfile_if;
  logic [13:0] rd_addr;
  logic [31:0] rd_data;
  logic        csr_wr_en;
  logic [13:0] wr_csr_addr;
  logic [31:0] wr_csr_data;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;

  modport master (
    output rd_addr, csr_wr_en, wr_csr_addr, wr_csr_data,
    output excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode,
    output va_error, bad_va,
    input  rd_data
  );

  modport slave (
    input  rd_addr, csr_wr_en, wr_csr_addr, wr_csr_data,
    input  excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode,
    input  va_error, bad_va,
    output rd_data
  );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch architectural CSR file: exception/ertn state, interrupt status,
// constant timer and free-running stable counter.
module csr_regfile #(
  parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
  parameter int          CNT_W      = 64
) (
  input  logic             clk,
  input  logic             reset,
  csr_regfile_if.slave     bus,
  input  logic [7:0]       hw_int_in,
  input  logic             ipi_int_in,
  output logic [31:0]      ex_entry,
  output logic [31:0]      ertn_pc,
  output logic             has_int,
  output logic [CNT_W-1:0] stable_cnt,
  output logic [31:0]      counter_id
);

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic [1:0]  crmd_plv;
  logic        crmd_ie, crmd_da, crmd_pg;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        is_timer, is_ipi;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era, badv, tid, tcfg, tval;
  logic [31:0] save [4];
  logic [25:0] eentry;
  logic [12:0] int_status;

  logic wr_ok, tcfg_load, ticlr, timer_fire;

  // Exceptions and ertn both take the commit slot, so a coincident CSR write is dropped.
  assign wr_ok      = bus.csr_wr_en & ~bus.excp_flush & ~bus.ertn_flush;
  assign tcfg_load  = wr_ok && bus.wr_csr_addr == A_TCFG  && bus.wr_csr_data[0];
  assign ticlr      = wr_ok && bus.wr_csr_addr == A_TICLR && bus.wr_csr_data[0];
  assign timer_fire = ~tcfg_load && tcfg[0] && tval == 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
      crmd_da   <= 1'b1;
      crmd_pg   <= 1'b0;
      prmd_pplv <= 2'd0;
      prmd_pie  <= 1'b0;
      ecfg_lie  <= 13'd0;
      is_sw     <= 2'd0;
      ecode     <= 6'd0;
      esubcode  <= 9'd0;
      era       <= 32'd0;
      badv      <= 32'd0;
      eentry    <= EENTRY_RST[31:6];
      save[0]   <= 32'd0;
      save[1]   <= 32'd0;
      save[2]   <= 32'd0;
      save[3]   <= 32'd0;
      tid       <= 32'd0;
      tcfg      <= 32'd0;
    end else if (bus.excp_flush) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
      crmd_plv  <= 2'd0;
      crmd_ie   <= 1'b0;
      era       <= bus.csr_era;
      ecode     <= bus.csr_ecode;
      esubcode  <= bus.csr_esubcode;
      if (bus.va_error) badv <= bus.bad_va;
    end else if (bus.ertn_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (wr_ok) begin
      case (bus.wr_csr_addr)
        A_CRMD:   {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= bus.wr_csr_data[4:0];
        A_PRMD:   {prmd_pie, prmd_pplv} <= bus.wr_csr_data[2:0];
        A_ECFG:   ecfg_lie <= bus.wr_csr_data[12:0] & 13'h1BFF;
        A_ESTAT:  is_sw <= bus.wr_csr_data[1:0];
        A_ERA:    era <= bus.wr_csr_data;
        A_BADV:   badv <= bus.wr_csr_data;
        A_EENTRY: eentry <= bus.wr_csr_data[31:6];
        A_SAVE0:  save[0] <= bus.wr_csr_data;
        A_SAVE1:  save[1] <= bus.wr_csr_data;
        A_SAVE2:  save[2] <= bus.wr_csr_data;
        A_SAVE3:  save[3] <= bus.wr_csr_data;
        A_TID:    tid <= bus.wr_csr_data;
        A_TCFG:   tcfg <= bus.wr_csr_data;
        default:  ;
      endcase
    end
  end

  // Interrupt lines are sampled every cycle regardless of commit activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_hw  <= 8'd0;
      is_ipi <= 1'b0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
    end
  end

  // 0xFFFF_FFFF in TVAL marks a stopped one-shot timer; an expiry beats a same-cycle TICLR.
  always_ff @(posedge clk) begin
    if (reset) begin
      tval     <= 32'hFFFF_FFFF;
      is_timer <= 1'b0;
    end else begin
      if (tcfg_load) begin
        tval <= {bus.wr_csr_data[31:2], 2'b00};
      end else if (tcfg[0] && tval != 32'hFFFF_FFFF) begin
        if (tval == 32'h0) tval <= tcfg[1] ? {tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
        else               tval <= tval - 32'd1;
      end
      if (timer_fire)  is_timer <= 1'b1;
      else if (ticlr)  is_timer <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stable_cnt <= '0;
    else       stable_cnt <= stable_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign int_status = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
  assign has_int    = crmd_ie & |(int_status & ecfg_lie);
  assign ex_entry   = {eentry, 6'b0};
  assign ertn_pc    = era;
  assign counter_id = tid;

  always_comb begin
    bus.rd_data = 32'd0;
    case (bus.rd_addr)
      A_CRMD:   bus.rd_data = {27'd0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      A_PRMD:   bus.rd_data = {29'd0, prmd_pie, prmd_pplv};
      A_ECFG:   bus.rd_data = {19'd0, ecfg_lie};
      A_ESTAT:  bus.rd_data = {1'b0, esubcode, ecode, 3'd0, int_status};
      A_ERA:    bus.rd_data = era;
      A_BADV:   bus.rd_data = badv;
      A_EENTRY: bus.rd_data = {eentry, 6'b0};
      A_SAVE0:  bus.rd_data = save[0];
      A_SAVE1:  bus.rd_data = save[1];
      A_SAVE2:  bus.rd_data = save[2];
      A_SAVE3:  bus.rd_data = save[3];
      A_TID:    bus.rd_data = tid;
      A_TCFG:   bus.rd_data = tcfg;
      A_TVAL:   bus.rd_data = tval;
      default:  bus.rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: a word-level CSR model predicts every
// observable output each cycle; a negedge monitor drains and compares.
module tb_csr_regfile;
  localparam logic [31:0] EENTRY_RST = 32'h1C00_003F;
  localparam int MAPPED[15] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC,
                                'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42, 'h44};

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry, ertn_pc, counter_id;
  logic        has_int;
  logic [63:0] stable_cnt;

  csr_regfile_if bus ();

  csr_regfile #(.EENTRY_RST(EENTRY_RST), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int),
    .stable_cnt(stable_cnt), .counter_id(counter_id)
  );

  always #5 clk = ~clk;

  // stimulus for the coming cycle
  logic        s_reset, s_wen, s_excp, s_ertn, s_va, s_ipi;
  logic [13:0] s_waddr, s_raddr;
  logic [31:0] s_wdata, s_era, s_badva;
  logic [5:0]  s_ecode;
  logic [8:0]  s_esub;
  logic [7:0]  s_hw;

  // reference model: CSR words keyed by address
  logic [31:0] m_csr [int];
  logic [63:0] m_cnt;
  bit          m_valid = 0;

  int          q_kind [$];
  int          q_addr [$];
  logic [63:0] q_exp  [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] wmask(int a);
    case (a)
      'h0:  return 32'h0000_001F;
      'h1:  return 32'h0000_0007;
      'h4:  return 32'h0000_1BFF;
      'h5:  return 32'h0000_0003;
      'hC:  return 32'hFFFF_FFC0;
      'h42, 'h44: return 32'h0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_read(int a);
    if (m_csr.exists(a)) return m_csr[a];
    return 32'h0;
  endfunction

  function automatic logic model_int();
    return m_csr['h0][2] && ((m_csr['h5] & m_csr['h4] & 32'h1FFF) != 0);
  endfunction

  task automatic model_reset();
    foreach (MAPPED[i]) m_csr[MAPPED[i]] = 32'h0;
    m_csr['h0]  = 32'h8;
    m_csr['h42] = 32'hFFFF_FFFF;
    m_csr['hC]  = EENTRY_RST & 32'hFFFF_FFC0;
    m_cnt = 64'd0;
  endtask

  task automatic model_step();
    logic [31:0] crmd, prmd, tcfg, tval, estat;
    bit wr, fire, load, clr;
    if (s_reset) begin
      model_reset();
      m_valid = 1;
      return;
    end
    crmd = m_csr['h0]; prmd = m_csr['h1]; tcfg = m_csr['h41]; tval = m_csr['h42];
    m_cnt = m_cnt + 64'd1;
    wr   = s_wen && !s_excp && !s_ertn;
    load = wr && s_waddr == 14'h41 && s_wdata[0];
    clr  = wr && s_waddr == 14'h44 && s_wdata[0];
    fire = 0;
    if (s_excp) begin
      m_csr['h1] = crmd & 32'h7;
      m_csr['h0] = crmd & ~32'h7;
      m_csr['h6] = s_era;
      m_csr['h5] = (m_csr['h5] & ~32'h7FFF_0000) | (32'(s_ecode) << 16) | (32'(s_esub) << 22);
      if (s_va) m_csr['h7] = s_badva;
    end else if (s_ertn) begin
      m_csr['h0] = (crmd & ~32'h7) | (prmd & 32'h7);
    end else if (wr && m_csr.exists(int'(s_waddr))) begin
      m_csr[int'(s_waddr)] = (m_csr[int'(s_waddr)] & ~wmask(int'(s_waddr))) |
                             (s_wdata & wmask(int'(s_waddr)));
    end
    if (load) m_csr['h42] = s_wdata & ~32'h3;
    else if (tcfg[0] && tval != 32'hFFFF_FFFF) begin
      if (tval == 0) begin
        fire = 1;
        m_csr['h42] = tcfg[1] ? (tcfg & ~32'h3) : 32'hFFFF_FFFF;
      end else m_csr['h42] = tval - 1;
    end
    estat = (m_csr['h5] & ~32'h13FC) | (32'(s_hw) << 2) | (32'(s_ipi) << 12);
    if (fire)     estat = estat | 32'h800;
    else if (clr) estat = estat & ~32'h800;
    m_csr['h5] = estat;
  endtask

  task automatic push(int kind, int addr, logic [63:0] e);
    q_kind.push_back(kind); q_addr.push_back(addr); q_exp.push_back(e);
  endtask

  task automatic applyStimulus();
    reset             = s_reset;
    bus.rd_addr       = s_raddr;
    bus.csr_wr_en     = s_wen;
    bus.wr_csr_addr   = s_waddr;
    bus.wr_csr_data   = s_wdata;
    bus.excp_flush    = s_excp;
    bus.ertn_flush    = s_ertn;
    bus.csr_era       = s_era;
    bus.csr_ecode     = s_ecode;
    bus.csr_esubcode  = s_esub;
    bus.va_error      = s_va;
    bus.bad_va        = s_badva;
    hw_int_in         = s_hw;
    ipi_int_in        = s_ipi;
    if (m_valid) begin
      push(0, int'(s_raddr), 64'(model_read(int'(s_raddr))));
      push(1, 0, 64'(model_int()));
      push(2, 0, 64'(m_csr['hC]));
      push(3, 0, 64'(m_csr['h6]));
      push(4, 0, m_cnt);
      push(5, 0, 64'(m_csr['h40]));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic checkOutput(int kind, int addr, logic [63:0] e);
    logic [63:0] act;
    string nm;
    case (kind)
      0: begin act = 64'(bus.rd_data); nm = $sformatf("rd_data[0x%0h]", addr); end
      1: begin act = 64'(has_int);     nm = "has_int";    end
      2: begin act = 64'(ex_entry);    nm = "ex_entry";   end
      3: begin act = 64'(ertn_pc);     nm = "ertn_pc";    end
      4: begin act = stable_cnt;       nm = "stable_cnt"; end
      default: begin act = 64'(counter_id); nm = "counter_id"; end
    endcase
    n_checks++;
    if (act === e) n_pass++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, e, $time);
  endtask

  always @(negedge clk) begin
    while (q_kind.size() > 0)
      checkOutput(q_kind.pop_front(), q_addr.pop_front(), q_exp.pop_front());
  end

  task automatic idle(logic [13:0] raddr);
    s_reset = 0; s_wen = 0; s_excp = 0; s_ertn = 0; s_va = 0;
    s_waddr = 14'h0; s_wdata = 32'h0; s_era = 32'h0; s_badva = 32'h0;
    s_ecode = 6'h0; s_esub = 9'h0; s_raddr = raddr;
  endtask

  task automatic readCsr(logic [13:0] a);
    idle(a); applyStimulus();
  endtask

  task automatic writeCsr(logic [13:0] a, logic [31:0] d, logic [13:0] raddr);
    idle(raddr); s_wen = 1; s_waddr = a; s_wdata = d; applyStimulus();
  endtask

  task automatic doReset();
    idle(14'h0); s_reset = 1; applyStimulus();
  endtask

  initial begin
    s_hw = 8'h0; s_ipi = 0;
    doReset(); doReset();
    $display("[TB] reset values");
    foreach (MAPPED[i]) readCsr(14'(MAPPED[i]));
    readCsr(14'h3FF);

    $display("[TB] exception with ecode, coincident SAVE0 write");
    writeCsr(14'h0, 32'h7, 14'h0);
    writeCsr(14'hC, 32'h1C00_8040, 14'hC);
    idle(14'h0); s_excp = 1; s_era = 32'h1C00_0100; s_ecode = 6'h0B;
    s_wen = 1; s_waddr = 14'h30; s_wdata = 32'hDEAD_BEEF; applyStimulus();
    foreach (MAPPED[i]) readCsr(14'(MAPPED[i]));

    $display("[TB] ALE with bad address, then ertn");
    writeCsr(14'h0, 32'h5, 14'h0);
    idle(14'h7); s_excp = 1; s_era = 32'h1C00_0200; s_ecode = 6'h09;
    s_va = 1; s_badva = 32'h8000_0003; applyStimulus();
    readCsr(14'h7); readCsr(14'h1);
    idle(14'h0); s_ertn = 1; s_wen = 1; s_waddr = 14'h31; s_wdata = 32'h1234; applyStimulus();
    readCsr(14'h0); readCsr(14'h31);

    $display("[TB] one-shot timer");
    writeCsr(14'h41, 32'h0000_0011, 14'h42);
    for (int i = 0; i < 20; i++) readCsr((i % 4 == 3) ? 14'h5 : 14'h42);
    readCsr(14'h5);
    writeCsr(14'h44, 32'h1, 14'h44);
    readCsr(14'h5);

    $display("[TB] periodic timer with TICLR racing expiry");
    writeCsr(14'h41, 32'h0000_000B, 14'h42);
    for (int i = 0; i < 12; i++) readCsr((i % 2) ? 14'h5 : 14'h42);
    for (int i = 0; i < 20; i++) writeCsr(14'h44, 32'h1, 14'h5);
    readCsr(14'h5);

    $display("[TB] reset during countdown");
    writeCsr(14'h41, 32'h0000_0101, 14'h42);
    for (int i = 0; i < 5; i++) readCsr(14'h42);
    doReset();
    readCsr(14'h42); readCsr(14'h41); readCsr(14'h5);

    $display("[TB] interrupt enable path");
    writeCsr(14'h4, 32'h0000_0004, 14'h4);
    writeCsr(14'h0, 32'h0000_0004, 14'h0);
    s_hw = 8'h01;
    for (int i = 0; i < 3; i++) readCsr(14'h5);
    writeCsr(14'h0, 32'h0, 14'h0);
    readCsr(14'h5);
    s_hw = 8'h00;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      idle($urandom_range(0, 7) == 0 ? 14'($urandom_range(0, 16383))
                                     : 14'(MAPPED[$urandom_range(0, 14)]));
      s_hw  = 8'($urandom_range(0, 255)) & (($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00);
      s_ipi = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        s_wen   = 1;
        s_waddr = 14'(MAPPED[$urandom_range(0, 14)]);
        s_wdata = $urandom();
        if (s_waddr == 14'h41) s_wdata = 32'($urandom_range(0, 63));
      end
      s_excp = ($urandom_range(0, 15) == 0);
      s_ertn = ($urandom_range(0, 15) == 0);
      s_era = $urandom(); s_ecode = 6'($urandom()); s_esub = 9'($urandom());
      s_va = 1'($urandom()); s_badva = $urandom();
      s_reset = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    idle(14'h0); s_hw = 8'h0; s_ipi = 0;
    applyStimulus();
    @(negedge clk); #1;
    n_checks++;
    if (q_kind.size() == 0) n_pass++;
    else $display("[TB] FAIL scoreboard_drain actual=%0d pending expected=0", q_kind.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
